// File: rtl/udma_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_rx_pkg                                                          |
// | Datasize encodings and datasize-to-byte-count mapping for uDMA RX.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package udma_rx_pkg;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;

  // Encoding 2'b11 is treated as a full word.
  function automatic logic [2:0] ds_to_n(input logic [1:0] ds);
    case (ds)
      DS_BYTE: return 3'd1;
      DS_HALF: return 3'd2;
      DS_WORD: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/udma_rx_out_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_rx_out_slice                                                    |
// | Single-entry valid/ready output register holding a word + byte count.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module udma_rx_out_slice #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_bytes,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [2:0]        o_bytes,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_bytes;
  logic              r_valid;

  // A load wins over a drain so a word can enter as the previous one leaves.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_data  <= '0;
      r_bytes <= '0;
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_data  <= '0;
      r_bytes <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_bytes <= i_bytes;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_bytes = r_bytes;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/udma_rx_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udma_rx_byte_packer                                                  |
// | Packs RX bytes little-endian into 1/2/4-byte words, with flush.      |
// | Optional word counter: define UDMA_RX_PACKER_STATS_EN.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module udma_rx_byte_packer
  import udma_rx_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [1:0]           cfg_datasize_i,
  input  logic                 flush_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [2:0]           out_bytes_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [15:0]          stat_words_o
);

  logic [1:0]           r_cnt;
  logic [OUT_WIDTH-1:0] r_acc;
  logic                 r_flush_pend;
  logic [2:0]           r_size;

  logic [2:0]           w_n;
  logic [2:0]           w_cnt_inc;
  logic                 w_space;
  logic                 w_accept;
  logic                 w_complete;
  logic                 w_flush_go;
  logic                 w_load;
  logic [OUT_WIDTH-1:0] w_acc_new;
  logic [OUT_WIDTH-1:0] w_load_data;
  logic [2:0]           w_load_bytes;

  // An empty accumulator follows the live datasize; a started word keeps the latched one.
  assign w_n        = (r_cnt == 2'd0) ? ds_to_n(cfg_datasize_i) : r_size;
  assign w_cnt_inc  = {1'b0, r_cnt} + 3'd1;
  assign w_space    = ~out_valid_o | out_ready_i;
  assign in_ready_o = cfg_en_i & ~r_flush_pend & ((w_cnt_inc != w_n) | w_space);
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_complete = w_accept & (w_cnt_inc == w_n);
  assign w_flush_go = r_flush_pend & w_space;
  assign w_acc_new  = r_acc | ({{(OUT_WIDTH-IN_WIDTH){1'b0}}, in_data_i} << {r_cnt, 3'b000});

  assign w_load       = cfg_en_i & (w_complete | w_flush_go);
  assign w_load_data  = w_complete ? w_acc_new : r_acc;
  assign w_load_bytes = w_complete ? w_n : {1'b0, r_cnt};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_size <= 3'd4;
    end else if (r_cnt == 2'd0) begin
      r_size <= ds_to_n(cfg_datasize_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_flush_pend <= 1'b0;
    end else if (!cfg_en_i) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_flush_go) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= w_cnt_inc[1:0];
        r_acc <= w_acc_new;
        // The byte is packed first, so a flush always sees a non-empty word here.
        if (flush_i) r_flush_pend <= 1'b1;
      end
    end else if (flush_i && (r_cnt != 2'd0)) begin
      r_flush_pend <= 1'b1;
    end
  end

  udma_rx_out_slice #(
    .DATA_W (OUT_WIDTH)
  ) u_out_slice (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_clr   (~cfg_en_i),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_bytes (w_load_bytes),
    .i_ready (out_ready_i),
    .o_data  (out_data_o),
    .o_bytes (out_bytes_o),
    .o_valid (out_valid_o)
  );

`ifdef UDMA_RX_PACKER_STATS_EN
  logic [15:0] r_stat_words;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stat_words <= '0;
    end else if (out_valid_o && out_ready_i && (r_stat_words != 16'hFFFF)) begin
      r_stat_words <= r_stat_words + 16'd1;
    end
  end

  assign stat_words_o = r_stat_words;
`else
  assign stat_words_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/udma_rx_byte_packer.md
Name: udma_rx_byte_packer

Overview:
- Sits directly downstream of the uDMA RX clock-domain-crossing FIFO, in the uDMA/L2 clock domain.
- Consumes the 8-bit peripheral byte stream from the FIFO's destination side.
- Packs 1, 2 or 4 bytes, little-endian, into 32-bit words according to the channel datasize, and presents them to the RX channel with valid/ready.
- Supports a flush that emits a partial word at end of transfer.

Parameters:
- IN_WIDTH, 8, input beat width in bits; fixed at 8, other values unsupported.
- OUT_WIDTH, 32, output word width; must equal 4*IN_WIDTH.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset: asynchronous, active-low.
- cfg_en_i  in  1  channel enable; low acts as a synchronous soft clear.
- cfg_datasize_i  in  2  00=byte, 01=half, 10=word, 11=word.
- flush_i  in  1  single-cycle request to emit the partial word.
- in_data_i  in  8  byte from the CDC FIFO.
- in_valid_i  in  1  byte valid.
- in_ready_o  out  1  byte accepted when in_valid_i & in_ready_o.
- out_data_o  out  32  packed word; unused upper bytes are zero.
- out_bytes_o  out  3  valid byte count in out_data_o, range 1..4.
- out_valid_o  out  1  word valid.
- out_ready_i  in  1  consumer ready.
- stat_words_o  out  16  emitted-word counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; internal acc=0, cnt=0, flush_pend=0, size latch=word.
- Datasize latching:
  - N = 1/2/4 from cfg_datasize_i.
  - Latched into the size register only while cnt==0.
  - Changes mid-word are ignored until the word completes.
- Packing:
  - Accepted byte k (k=cnt) lands in acc[8k+7:8k]; cnt increments.
  - When the accepted byte makes cnt reach N, the full word moves to the output register, out_bytes_o=N, and cnt/acc clear in the same cycle.
- Output register:
  - One entry, independent of acc.
  - out_valid_o rises the cycle after the completing byte is accepted (latency 1).
  - Holds data stable until out_valid_o & out_ready_i.
  - Load and drain in the same cycle is allowed, giving 1 word per N cycles sustained.
- in_ready_o = cfg_en_i & ~flush_pend & (cnt!=N-1 | ~out_valid_o | out_ready_i).
  - Combinational from out_ready_i; no combinational path from in_valid_i.
- Flush:
  - flush_i sets flush_pend if cnt!=0; if cnt==0 it is a no-op.
  - While pending, input is stalled.
  - When the output register is free or draining, acc moves out zero-filled with out_bytes_o=cnt, then flush_pend and cnt clear.
- Simultaneous flush_i and accepted byte: the byte is packed first, then the flush applies to the result. If that byte completed the word, the flush is a no-op.
- cfg_en_i low:
  - Clears cnt, acc, flush_pend and out_valid_o next cycle; any pending word is dropped.
  - in_ready_o=0.
  - stat_words_o is not cleared.
- Asynchronous reset mid-transfer returns every register to its reset value immediately; no partial word is emitted.

Optional Feature:
- Macro UDMA_RX_PACKER_STATS_EN.
- Defined: stat_words_o increments on each out_valid_o & out_ready_i, saturates at 16'hFFFF, and is cleared only by rstn_i.
- Undefined: stat_words_o tied to 0 and no counter flops exist.

Decomposition:
- Package udma_rx_pkg:
  - datasize localparams DS_BYTE=2'b00, DS_HALF=2'b01, DS_WORD=2'b10.
  - function datasize→N.
- One natural sub-module, udma_rx_out_slice: the single-entry valid/ready output register holding data plus byte count.

Test Plan:
- Datasize 10; bytes 11,22,33,44 streamed with out_ready_i=1 → one word 0x44332211, out_bytes_o=4, out_valid_o high 1 cycle after byte 44.
- Datasize 01; bytes AA,BB,CC,DD → words 0x0000BBAA then 0x0000DDCC, each with out_bytes_o=2.
- Datasize 10; bytes 01,02,03, then flush_i → word 0x00030201 with out_bytes_o=3; in_ready_o low until the word is loaded.
- out_ready_i held 0 with a full word in the output register; 4 more bytes offered → 3 accepted, 4th stalled (in_ready_o=0); out_ready_i=1 → both words emerge in order.
- cfg_datasize_i changed 10→00 after 2 bytes → current word still completes as 4 bytes; next bytes emit singly with out_bytes_o=1.
- cfg_en_i dropped with cnt=2 and out_valid_o=1 → next cycle out_valid_o=0, cnt=0. With UDMA_RX_PACKER_STATS_EN, 3 emitted words give stat_words_o=3.
